rx_token_scheduler: RTL and testbench
=====================================

// Module: rx_token_scheduler
// PURPOSE
//  Round-robin token scheduler sharing one downstream packet sink among NUM_PORTS
//  serial receivers. Passes a token between ports and drives each receiver's
//  RX_Ready handshake. Captures the 55-bit packet from the token holder and
//  offers it on a single valid/ready output. Sits between the receiver array and
//  the router core input.
// PARAMETERS
//  NUM_PORTS    4   number of receivers served (>=2)
//  PKT_W        55  packet width (matches receiver RX_Data)
//  POLL_CYCLES  16  cycles a port holds the token waiting for RX_Data_Valid (>=2)
//  SRC_W        2   port-index width, = clog2(NUM_PORTS)
// PORTS
//  Clk_S          in   1              system clock, all logic on posedge
//  Rst            in   1              synchronous, active-high reset
//  Port_En        in   NUM_PORTS      per-port enable mask; disabled ports skipped
//  RX_Data_Valid  in   NUM_PORTS      receiver valid flags, bit i = port i
//  RX_Data        in   NUM_PORTS*PKT_W  flattened packets, port i at [i*PKT_W +: PKT_W]
//  RX_Ready       out  NUM_PORTS      one-hot (or zero) grant to receivers, registered
//  Pkt_Data       out  PKT_W          captured packet, registered
//  Pkt_Src        out  SRC_W          port index Pkt_Data came from
//  Pkt_Valid      out  1              Pkt_Data valid
//  Pkt_Ready      in   1              sink accepts when Pkt_Valid & Pkt_Ready at posedge
//  Token          out  SRC_W          current token holder
// BEHAVIOUR
//  Reset (Rst=1 at posedge): state=IDLE, Token=0, RX_Ready=0, Pkt_Valid=0,
//    Pkt_Data=0, Pkt_Src=0, poll counter=0, captured flag=0.
//    Mid-operation reset discards any held packet. Pkt_Valid is low after that edge.
//  Next-port rule: first enabled port searched from Token+1 mod NUM_PORTS. Wraps
//    N-1 -> 0. If only the current port is enabled, the rule picks it again.
//    Port_En is sampled only at token advance; changes mid-slot do not abort the slot.
//  IDLE: RX_Ready=0. If Port_En!=0: Token <= first enabled port searched from
//    Token (inclusive), then -> POLL. If Port_En==0: stay in IDLE.
//  POLL: RX_Ready[Token]=1, all other bits 0. Counter increments each cycle.
//    - RX_Data_Valid[Token]=1 at posedge: Pkt_Data<=RX_Data[Token],
//      Pkt_Src<=Token, Pkt_Valid<=1, captured<=1, RX_Ready<=0 -> OFFER.
//    - Else, counter==POLL_CYCLES-1: RX_Ready<=0 -> RELEASE.
//      RX_Ready is high for exactly POLL_CYCLES cycles.
//    - Valid of non-token ports is ignored.
//  OFFER: RX_Ready=0. Pkt_Data/Pkt_Src held stable while Pkt_Valid & ~Pkt_Ready.
//    Accept at posedge -> Pkt_Valid<=0 -> RELEASE.
//  RELEASE: RX_Ready=0. Covers the receiver's one-cycle lag in dropping valid.
//    - RX_Data_Valid[Token]=1 and captured=0 (late valid after timeout):
//      capture as in POLL -> OFFER. No packet is lost.
//    - RX_Data_Valid[Token]=1 and captured=1: wait.
//    - RX_Data_Valid[Token]=0: captured<=0, counter<=0, Token<=next port.
//      -> POLL, or -> IDLE if Port_En==0.
//  Latency: with receiver data pending, RX_Ready rises -> valid 1 cycle later ->
//    Pkt_Valid 1 cycle after that. Minimum slot = POLL 2 + OFFER 1 + RELEASE 1 cycles.
//  Invariants: RX_Ready has at most one bit set. RX_Ready and Pkt_Valid are never
//    high together. At most one packet is held (no buffering).
//  Counter width: clog2(POLL_CYCLES). No overflow possible (reset each slot).
// TESTING
//  1 Rst=1 for 2 cycles, Port_En=4'hF -> all outputs 0, Token=0.
//    First cycle after release: RX_Ready=4'b0001.
//  2 Only port 2 pending, data 55'h0AB_CDEF -> RX_Ready[0] high 16 cycles,
//    then RX_Ready[1] high 16 cycles, then port 2 serviced:
//    Pkt_Data=55'h0AB_CDEF, Pkt_Src=2.
//  3 Packet held, Pkt_Ready=0 for 10 cycles -> Pkt_Valid/Pkt_Data/Pkt_Src stable,
//    RX_Ready=0, Token frozen. Accept -> Pkt_Valid=0 next cycle.
//  4 Port_En=4'b1010, all ports pending -> sources seen 1,3,1,3.
//    RX_Ready[0] and RX_Ready[2] never high. Port_En=0 -> IDLE, RX_Ready=0.
//  5 Receiver valid rises on the edge the POLL timeout drops RX_Ready ->
//    packet captured in RELEASE, Pkt_Src=Token, no loss, no duplicate.
//  6 Rst pulse while in OFFER -> Pkt_Valid=0 and Token=0 after that edge.
//    Polling restarts at port 0.

Source files
------------

// File: rtl/rx_token_scheduler.sv
// rx_token_scheduler: round-robin token poller granting receivers in turn and forwarding one packet at a time to a valid/ready sink
module rx_token_scheduler #(
    parameter int NUM_PORTS   = 4,
    parameter int PKT_W       = 55,
    parameter int POLL_CYCLES = 16,
    parameter int SRC_W       = $clog2(NUM_PORTS)
) (
    input  logic                       Clk_S,
    input  logic                       Rst,
    input  logic [NUM_PORTS-1:0]       Port_En,
    input  logic [NUM_PORTS-1:0]       RX_Data_Valid,
    input  logic [NUM_PORTS*PKT_W-1:0] RX_Data,
    output logic [NUM_PORTS-1:0]       RX_Ready,
    output logic [PKT_W-1:0]           Pkt_Data,
    output logic [SRC_W-1:0]           Pkt_Src,
    output logic                       Pkt_Valid,
    input  logic                       Pkt_Ready,
    output logic [SRC_W-1:0]           Token
);
    localparam int CNT_W = $clog2(POLL_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(POLL_CYCLES - 1);
    localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);
    localparam logic [1:0] IDLE = 2'd0, POLL = 2'd1, OFFER = 2'd2, RELEASE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [SRC_W-1:0]     token_q, token_d, pkt_src_q, pkt_src_d;
    logic [NUM_PORTS-1:0] rx_ready_q, rx_ready_d;
    logic [PKT_W-1:0]     pkt_data_q, pkt_data_d;
    logic                 pkt_valid_q, pkt_valid_d, captured_q, captured_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PKT_W-1:0]     rx_pkt [NUM_PORTS];
    logic [SRC_W-1:0]     nxt_incl, nxt_excl;
    logic                 tok_valid;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign rx_pkt[g] = RX_Data[g*PKT_W +: PKT_W];
    end

    // lowest rotation offset wins, so the search runs from the far end back to start
    function automatic logic [SRC_W-1:0] first_en(input logic [NUM_PORTS-1:0] en, input int start);
        logic [SRC_W-1:0]     r;
        logic [NUM_PORTS-1:0] rot;
        int                   idx;
        r = SRC_W'(start % NUM_PORTS);
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = (start + k) % NUM_PORTS;
            rot = en >> idx;
            if (rot[0]) r = SRC_W'(idx);
        end
        return r;
    endfunction

    assign nxt_incl  = first_en(Port_En, int'(token_q));
    assign nxt_excl  = first_en(Port_En, int'(token_q) + 1);
    assign tok_valid = RX_Data_Valid[token_q];

    always_comb begin
        state_d     = state_q;
        token_d     = token_q;
        rx_ready_d  = rx_ready_q;
        pkt_data_d  = pkt_data_q;
        pkt_src_d   = pkt_src_q;
        pkt_valid_d = pkt_valid_q;
        captured_d  = captured_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (|Port_En) begin
                token_d    = nxt_incl;
                rx_ready_d = ONE << nxt_incl;
                cnt_d      = '0;
                state_d    = POLL;
            end
            POLL: begin
                cnt_d = cnt_q + 1'b1;
                if (tok_valid || cnt_q == LAST) begin
                    rx_ready_d = '0;
                    state_d    = tok_valid ? OFFER : RELEASE;
                end
                if (tok_valid) begin
                    pkt_data_d  = rx_pkt[token_q];
                    pkt_src_d   = token_q;
                    pkt_valid_d = 1'b1;
                    captured_d  = 1'b1;
                end
            end
            OFFER: if (Pkt_Ready) begin
                pkt_valid_d = 1'b0;
                state_d     = RELEASE;
            end
            default: begin
                // a valid still high after our own capture is the receiver's lag, not a new packet
                if (tok_valid && !captured_q) begin
                    pkt_data_d  = rx_pkt[token_q];
                    pkt_src_d   = token_q;
                    pkt_valid_d = 1'b1;
                    captured_d  = 1'b1;
                    state_d     = OFFER;
                end else if (!tok_valid) begin
                    captured_d = 1'b0;
                    cnt_d      = '0;
                    token_d    = (|Port_En) ? nxt_excl : token_q;
                    rx_ready_d = (|Port_En) ? ONE << nxt_excl : '0;
                    state_d    = (|Port_En) ? POLL : IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk_S) begin
        if (Rst) begin
            state_q     <= IDLE;
            token_q     <= '0;
            rx_ready_q  <= '0;
            pkt_data_q  <= '0;
            pkt_src_q   <= '0;
            pkt_valid_q <= 1'b0;
            captured_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            token_q     <= token_d;
            rx_ready_q  <= rx_ready_d;
            pkt_data_q  <= pkt_data_d;
            pkt_src_q   <= pkt_src_d;
            pkt_valid_q <= pkt_valid_d;
            captured_q  <= captured_d;
            cnt_q       <= cnt_d;
        end
    end

    assign RX_Ready  = rx_ready_q;
    assign Pkt_Data  = pkt_data_q;
    assign Pkt_Src   = pkt_src_q;
    assign Pkt_Valid = pkt_valid_q;
    assign Token     = token_q;
endmodule

// File: tb/tb_rx_token_scheduler.sv
// tb_rx_token_scheduler: scoreboard bench with modelled receivers and a slot-level round-robin reference
module tb_rx_token_scheduler;
    localparam int N = 4, W = 55, PC = 16, SW = 2;

    logic           Clk_S = 1'b0;
    logic           Rst = 1'b1;
    logic [N-1:0]   Port_En, RX_Data_Valid, RX_Ready;
    logic [N*W-1:0] RX_Data;
    logic [W-1:0]   Pkt_Data;
    logic [SW-1:0]  Pkt_Src, Token;
    logic           Pkt_Valid, Pkt_Ready;

    always #5 Clk_S = ~Clk_S;

    rx_token_scheduler #(.NUM_PORTS(N), .PKT_W(W), .POLL_CYCLES(PC), .SRC_W(SW)) dut (
        .Clk_S(Clk_S), .Rst(Rst), .Port_En(Port_En), .RX_Data_Valid(RX_Data_Valid),
        .RX_Data(RX_Data), .RX_Ready(RX_Ready), .Pkt_Data(Pkt_Data), .Pkt_Src(Pkt_Src),
        .Pkt_Valid(Pkt_Valid), .Pkt_Ready(Pkt_Ready), .Token(Token)
    );

    typedef struct packed {
        logic [SW-1:0] src;
        logic [W-1:0]  data;
    } pkt_t;

    pkt_t         exp_q[$];
    pkt_t         e;
    logic [W-1:0] rq [N][$];
    logic [N-1:0] rv, rdy_s, seen_rdy;
    int           errors = 0, checks = 0, ready_pct = 100;
    logic         prev_hold = 1'b0, prev_acc = 1'b0;
    logic [W-1:0] h_data;
    logic [SW-1:0] h_src, h_tok;

    task automatic chk(input logic ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive_rx();
        for (int i = 0; i < N; i++) begin
            RX_Data_Valid[i] = rv[i];
            RX_Data[i*W +: W] = (rq[i].size() > 0) ? rq[i][0] : W'({$urandom(), $urandom()});
        end
    endtask

    // receiver: valid follows its own ready one cycle late; the packet leaves when valid falls
    task automatic tick();
        logic nv;
        rdy_s = RX_Ready;
        @(posedge Clk_S);
        #1;
        for (int i = 0; i < N; i++) begin
            nv = rdy_s[i] && rq[i].size() > 0;
            if (rv[i] && !nv && rq[i].size() > 0) void'(rq[i].pop_front());
            rv[i] = nv;
        end
        Pkt_Ready = ($urandom_range(0, 99) < ready_pct);
        drive_rx();
        seen_rdy |= RX_Ready;
    endtask

    task automatic do_reset(input logic [N-1:0] en);
        exp_q.delete();
        Rst = 1'b1;
        Port_En = en;
        for (int i = 0; i < N; i++) rq[i].delete();
        rv = '0;
        drive_rx();
        tick();
        tick();
        @(negedge Clk_S);
        chk(RX_Ready == 0 && !Pkt_Valid && Pkt_Data == 0 && Pkt_Src == 0 && Token == 0,
            "reset_state", {RX_Ready, Pkt_Valid, Pkt_Src, Token}, 64'h0);
        #1 Rst = 1'b0;
        seen_rdy = '0;
    endtask

    task automatic load(input int p, input int n);
        repeat (n) rq[p].push_back(W'({$urandom(), $urandom()}));
    endtask

    // reference: token visits enabled ports in ring order from port 0; a visit with data yields one packet
    task automatic model(input logic [N-1:0] en);
        logic [W-1:0] m [N][$];
        int t, left;
        left = 0;
        for (int i = 0; i < N; i++) begin
            m[i] = rq[i];
            if (en[i]) left += m[i].size();
        end
        t = 0;
        while (!en[t]) t++;
        while (left > 0) begin
            if (m[t].size() > 0) begin
                exp_q.push_back('{src: SW'(t), data: m[t].pop_front()});
                left--;
            end
            t = (t + 1) % N;
            while (!en[t]) t = (t + 1) % N;
        end
    endtask

    task automatic drain(input int budget, input string name);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            tick();
            c++;
        end
        chk(exp_q.size() == 0, name, 64'(exp_q.size()), 64'h0);
        exp_q.delete();
    endtask

    always @(negedge Clk_S) begin
        if (Rst) begin
            prev_hold = 1'b0;
            prev_acc  = 1'b0;
        end else begin
            chk($onehot0(RX_Ready) && !(|RX_Ready && Pkt_Valid), "ready_excl", {RX_Ready, Pkt_Valid}, 64'h0);
            if (prev_hold)
                chk(Pkt_Valid && Pkt_Data == h_data && Pkt_Src == h_src && Token == h_tok && RX_Ready == 0,
                    "hold_stable", {Pkt_Valid, Pkt_Src, Token, RX_Ready}, {1'b1, h_src, h_tok, 4'h0});
            if (prev_acc) chk(!Pkt_Valid, "valid_drop", 64'(Pkt_Valid), 64'h0);
            prev_hold = Pkt_Valid && !Pkt_Ready;
            prev_acc  = Pkt_Valid && Pkt_Ready;
            h_data = Pkt_Data;
            h_src  = Pkt_Src;
            h_tok  = Token;
            if (Pkt_Valid && Pkt_Ready) begin
                if (exp_q.size() == 0) chk(1'b0, "unexpected_pkt", 64'(Pkt_Src), 64'h0);
                else begin
                    e = exp_q.pop_front();
                    chk(Pkt_Src == e.src, "pkt_src", 64'(Pkt_Src), 64'(e.src));
                    chk(Pkt_Data == e.data, "pkt_data", 64'(Pkt_Data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] want[$];
        logic [W-1:0] x;
        logic [N-1:0] en;
        int c;
        Port_En = '1;
        Pkt_Ready = 1'b0;
        rv = '0;
        RX_Data = '0;
        RX_Data_Valid = '0;
        seen_rdy = '0;

        // only port 2 pending: two full timeouts, then port 2 serviced
        ready_pct = 0;
        do_reset(4'hF);
        rq[2].push_back(55'h0AB_CDEF);
        exp_q.push_back('{src: 2'd2, data: 55'h0AB_CDEF});
        drive_rx();
        repeat (PC) want.push_back(4'b0001);
        want.push_back(4'b0000);
        repeat (PC) want.push_back(4'b0010);
        want.push_back(4'b0000);
        repeat (2) want.push_back(4'b0100);
        want.push_back(4'b0000);
        for (int k = 0; k < want.size(); k++) begin
            tick();
            @(negedge Clk_S);
            chk(RX_Ready == want[k], $sformatf("ready_seq[%0d]", k), 64'(RX_Ready), 64'(want[k]));
        end

        // back-pressure hold, then accept
        repeat (10) tick();
        @(negedge Clk_S);
        chk(Pkt_Valid && Token == 2 && RX_Ready == 0, "held_10", {Pkt_Valid, Token, RX_Ready}, {1'b1, 2'd2, 4'h0});
        ready_pct = 100;
        drain(20, "t3_drain");

        // only odd ports enabled
        ready_pct = 70;
        do_reset(4'b1010);
        for (int i = 0; i < N; i++) load(i, 2);
        drive_rx();
        model(4'b1010);
        drain(1000, "t4_drain");
        chk((seen_rdy & 4'b0101) == 0, "t4_skip", 64'(seen_rdy), 64'h0);
        Port_En = '0;
        repeat (40) tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge Clk_S);
            chk(RX_Ready == 0, "t4_idle", 64'(RX_Ready), 64'h0);
        end

        // valid rises on the timeout edge
        ready_pct = 100;
        do_reset(4'b0001);
        repeat (PC) tick();
        x = W'({$urandom(), $urandom()});
        rq[0].push_back(x);
        exp_q.push_back('{src: 2'd0, data: x});
        drive_rx();
        tick();
        @(negedge Clk_S);
        chk(RX_Ready == 0 && !Pkt_Valid, "t5_timeout", {RX_Ready, Pkt_Valid}, 64'h0);
        tick();
        @(negedge Clk_S);
        chk(Pkt_Valid && Pkt_Src == 0 && Pkt_Data == x, "t5_late_capture", 64'(Pkt_Data), 64'(x));
        drain(20, "t5_drain");
        repeat (40) tick();

        // reset while offering
        ready_pct = 0;
        do_reset(4'hF);
        rq[0].push_back(W'({$urandom(), $urandom()}));
        drive_rx();
        c = 0;
        tick();
        while (!Pkt_Valid && c < 20) begin
            tick();
            c++;
        end
        chk(Pkt_Valid, "t6_offer", 64'(Pkt_Valid), 64'h1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        @(negedge Clk_S);
        chk(!Pkt_Valid && Token == 0, "t6_reset", {Pkt_Valid, Token}, 64'h0);
        tick();
        @(negedge Clk_S);
        chk(RX_Ready == 4'b0001, "t6_restart", 64'(RX_Ready), 64'h1);

        // randomized rounds
        repeat (8) begin
            ready_pct = $urandom_range(30, 100);
            en = N'($urandom_range(1, 15));
            do_reset(en);
            for (int i = 0; i < N; i++) load(i, $urandom_range(0, 3));
            drive_rx();
            model(en);
            drain(3000, "rand_drain");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
